// File: rtl/axi4_lite_reg_access_arb_pkg.sv
// Shared types and default widths for the two-requester AXI4-Lite register
// access arbiter.
//   state_e      : access FSM encoding
//   axi4_resp_t  : AXI BRESP/RRESP codes
//   DEF_*        : default address/data widths
package axi4_lite_reg_access_arb_pkg;

  localparam int DEF_ADDR_BIT_WIDTH = 4;
  localparam int DEF_DATA_BIT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_ACK          = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4_resp_t;

endpackage

// File: rtl/axi4_lite_reg_access_arb_if.sv
// AXI4-Lite bus bundle.
//   mst_port : drives AW/W/AR channels and bready/rready
//   slv_port : drives the ready signals and the B/R channels
interface axi4_lite_if
  import axi4_lite_reg_access_arb_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = DEF_ADDR_BIT_WIDTH,
  parameter int DATA_BIT_WIDTH = DEF_DATA_BIT_WIDTH
) ();
  logic                        awvalid;
  logic                        awready;
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        wvalid;
  logic                        wready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;
  logic                        arvalid;
  logic                        arready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        rvalid;
  logic                        rready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;

  modport mst_port (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slv_port (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/axi4_lite_reg_access_arb_rr_grant.sv
// Two-requester round-robin grant.
//   i_req   : request vector
//   i_en    : commit the current grant (advances the priority pointer)
//   o_valid : at least one request present
//   o_gnt   : index of the granted requester
module axi4_lite_rr_grant (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic       o_valid,
  output logic       o_gnt
);
  // prio_q points at the requester that wins a tie; it always moves to the
  // one not granted last, so reset value 0 gives requester 0 first priority.
  logic prio_q, prio_d;

  assign o_valid = |i_req;
  assign o_gnt   = i_req[prio_q] ? prio_q : ~prio_q;

  always_comb begin
    prio_d = prio_q;
    if (i_en && o_valid) prio_d = ~o_gnt;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) prio_q <= 1'b0;
    else           prio_q <= prio_d;
  end
endmodule

// File: rtl/axi4_lite_reg_access_arb.sv
// Arbitrates two simple request/ack register ports onto one AXI4-Lite
// master, one transaction at a time.
//   i_req/i_we/i_addr/i_wdata/i_wstrb : per-requester access request
//   o_ack                             : one-cycle completion pulse
//   o_rdata/o_resp                    : result of the last completed access
//   if_m_axi4_lite                    : AXI4-Lite master port
//
// state           | meaning
// ST_IDLE         | waiting for a request, grant on any i_req
// ST_WR_ADDR_DATA | AW and W valids outstanding
// ST_WR_RESP      | bready high, waiting for bvalid
// ST_RD_ADDR      | arvalid high, waiting for arready
// ST_RD_DATA      | rready high, waiting for rvalid
// ST_ACK          | o_ack pulse to the granted requester
module axi4_lite_reg_access_arb
  import axi4_lite_reg_access_arb_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = DEF_ADDR_BIT_WIDTH,
  parameter int DATA_BIT_WIDTH = DEF_DATA_BIT_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_req   [2],
  input  logic                        i_we    [2],
  input  logic [ADDR_BIT_WIDTH-1:0]   i_addr  [2],
  input  logic [DATA_BIT_WIDTH-1:0]   i_wdata [2],
  input  logic [DATA_BIT_WIDTH/8-1:0] i_wstrb [2],
  output logic                        o_ack   [2],
  output logic [DATA_BIT_WIDTH-1:0]   o_rdata,
  output logic [1:0]                  o_resp,
  axi4_lite_if.mst_port               if_m_axi4_lite
);
  if (ADDR_BIT_WIDTH != $bits(if_m_axi4_lite.awaddr)) begin : g_addr_chk
    $error("ADDR_BIT_WIDTH does not match the interface address width");
  end
  if (DATA_BIT_WIDTH != $bits(if_m_axi4_lite.wdata)) begin : g_data_chk
    $error("DATA_BIT_WIDTH does not match the interface data width");
  end

  state_e                      state_q, state_d;
  logic                        gnt_q, gnt_d;
  logic                        we_q, we_d;
  logic [ADDR_BIT_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                        bready_q, bready_d, arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic [1:0]                  ack_q, ack_d;
  logic [DATA_BIT_WIDTH-1:0]   rdata_q, rdata_d;
  axi4_resp_t                  resp_q, resp_d;

  logic any_req, gnt_idx, grant_en, aw_hs, w_hs;

  assign grant_en = (state_q == ST_IDLE);

  axi4_lite_rr_grant u_rr_grant (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_req    ({i_req[1], i_req[0]}),
    .i_en     (grant_en),
    .o_valid  (any_req),
    .o_gnt    (gnt_idx)
  );

  assign aw_hs = awvalid_q && if_m_axi4_lite.awready;
  assign w_hs  = wvalid_q && if_m_axi4_lite.wready;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = 2'b00;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = gnt_idx;
          we_d    = i_we[gnt_idx];
          addr_d  = i_addr[gnt_idx];
          wdata_d = i_wdata[gnt_idx];
          wstrb_d = i_wstrb[gnt_idx];
          if (i_we[gnt_idx]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // A channel is done if it already handshook or handshakes now.
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (if_m_axi4_lite.bvalid) begin
          resp_d       = axi4_resp_t'(if_m_axi4_lite.bresp);
          bready_d     = 1'b0;
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_ACK;
        end
      end
      ST_RD_ADDR: begin
        if (if_m_axi4_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (if_m_axi4_lite.rvalid) begin
          rdata_d      = if_m_axi4_lite.rdata;
          resp_d       = axi4_resp_t'(if_m_axi4_lite.rresp);
          rready_d     = 1'b0;
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 2'b00;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign o_ack[0] = ack_q[0];
  assign o_ack[1] = ack_q[1];
  assign o_rdata  = rdata_q;
  assign o_resp   = resp_q;

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = rready_q;
endmodule

// File: tb/tb_axi4_lite_reg_access_arb.sv
`timescale 1ns/1ps
module tb_axi4_lite_reg_access_arb;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [3:0]    wstrb [2];
  logic          ack   [2];
  logic [DW-1:0] rdata;
  logic [1:0]    resp;

  axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) bus ();

  axi4_lite_reg_access_arb #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_arst_n       (arst_n),
    .i_req          (req),
    .i_we           (we),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .i_wstrb        (wstrb),
    .o_ack          (ack),
    .o_rdata        (rdata),
    .o_resp         (resp),
    .if_m_axi4_lite (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave stub (register file of four words) ----------------
  int         aw_hold = 1, w_hold = 1, b_delay = 0;
  logic       err_mode = 1'b0;
  int         aw_cnt, w_cnt, b_wait;
  logic       aw_got, w_got, b_pending, bvalid_r, rvalid_r;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d, rdata_r;
  logic [3:0]    w_s;
  logic [1:0]    rresp_r;
  logic [31:0]   mem [4];
  logic aw_hs, w_hs, ar_hs;
  logic [1:0]  wr_idx;
  logic [31:0] wr_dat;
  logic [3:0]  wr_stb;

  assign bus.awready = bus.awvalid && (aw_cnt + 1 >= aw_hold);
  assign bus.wready  = bus.wvalid && (w_cnt + 1 >= w_hold);
  assign bus.arready = bus.arvalid;
  assign bus.bvalid  = bvalid_r;
  assign bus.bresp   = 2'b00;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign wr_idx = aw_hs ? bus.awaddr[3:2] : aw_a[3:2];
  assign wr_dat = w_hs ? bus.wdata : w_d;
  assign wr_stb = w_hs ? bus.wstrb : w_s;

  function automatic logic [31:0] stub_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial for (int i = 0; i < 4; i++) mem[i] = 32'h0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pending <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0; rdata_r <= '0; rresp_r <= 2'b00;
    end else begin
      aw_cnt <= (aw_hs || !bus.awvalid) ? 0 : aw_cnt + 1;
      w_cnt  <= (w_hs || !bus.wvalid) ? 0 : w_cnt + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
      if (w_hs) begin w_got <= 1'b1; w_d <= bus.wdata; w_s <= bus.wstrb; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[wr_idx] <= stub_merge(mem[wr_idx], wr_dat, wr_stb);
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (b_delay == 0) bvalid_r <= 1'b1;
        else begin b_pending <= 1'b1; b_wait <= 1; end
      end
      if (bvalid_r && bus.bready) bvalid_r <= 1'b0;
      else if (b_pending) begin
        if (b_wait >= b_delay) begin bvalid_r <= 1'b1; b_pending <= 1'b0; end
        else b_wait <= b_wait + 1;
      end
      if (ar_hs) begin
        rvalid_r <= 1'b1;
        rdata_r  <= mem[bus.araddr[3:2]];
        rresp_r  <= err_mode ? 2'b10 : 2'b00;
      end else if (rvalid_r && bus.rready) rvalid_r <= 1'b0;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    int          who;
    logic [31:0] rd;
    logic [1:0]  rs;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [4];
  logic [31:0] model_rdata;

  initial begin
    for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
    model_rdata = 32'h0;
  end

  function automatic logic [31:0] model_write(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic void expect_access(input int who, input logic w, input logic [3:0] a,
                                        input logic [31:0] d, input logic [3:0] s,
                                        input logic [1:0] rs);
    exp_t e;
    e.who = who;
    if (w) begin
      ref_mem[a[3:2]] = model_write(ref_mem[a[3:2]], d, s);
      e.rd = model_rdata;
      e.rs = 2'b00;
    end else begin
      model_rdata = ref_mem[a[3:2]];
      e.rd = model_rdata;
      e.rs = rs;
    end
    exp_q.push_back(e);
  endfunction

  // ---------------- per-cycle compare ----------------
  int ack_total = 0, awv_total = 0, wv_total = 0, bw_total = 0;
  logic          prev_awvalid = 1'b0, prev_wvalid = 1'b0;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    if (arst_n) begin
      if (ack[0] || ack[1]) begin
        exp_t e;
        check("single_ack", {31'd0, ack[0] && ack[1]}, 32'd0);
        ack_total++;
        if (exp_q.size() == 0) check("ack_expected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("ack_who", ack[1] ? 1 : 0, e.who);
          check("ack_rdata", rdata, e.rd);
          check("ack_resp", {30'd0, resp}, {30'd0, e.rs});
        end
      end
      if (bus.awvalid) check("awprot", {29'd0, bus.awprot}, 32'd0);
      if (bus.arvalid) check("arprot", {29'd0, bus.arprot}, 32'd0);
      if ((bus.awvalid || bus.wvalid || bus.bready) && (bus.arvalid || bus.rready))
        check("one_outstanding", 32'd1, 32'd0);
      if (prev_awvalid && bus.awvalid) check("awaddr_stable", {28'd0, bus.awaddr}, {28'd0, prev_awaddr});
      if (prev_wvalid && bus.wvalid) check("wdata_stable", bus.wdata, prev_wdata);
      if (bus.awvalid) awv_total++;
      if (bus.wvalid) wv_total++;
      if (bus.bready && !bus.bvalid) bw_total++;
    end
    prev_awvalid <= bus.awvalid && arst_n;
    prev_wvalid  <= bus.wvalid && arst_n;
    prev_awaddr  <= bus.awaddr;
    prev_wdata   <= bus.wdata;
  end

  // ---------------- stimulus ----------------
  // Issues one access, scrambles the requester's inputs once the bus shows
  // the access, and returns on the ack negedge with grant-to-ack latency.
  task automatic access(input int who, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [1:0] rs,
                        output int lat);
    int n, first;
    expect_access(who, w, a, d, s, rs);
    req[who] = 1'b1; we[who] = w; addr[who] = a; wdata[who] = d; wstrb[who] = s;
    n = 0; first = -1;
    do begin
      @(negedge clk);
      n++;
      if (first < 0 && (bus.awvalid || bus.arvalid)) begin
        first = n;
        we[who] = ~w; addr[who] = ~a; wdata[who] = ~d; wstrb[who] = ~s;
      end
    end while (!ack[who] && n < 60);
    check("ack_seen", {31'd0, ack[who]}, 32'd1);
    lat = (first < 0) ? 99 : n - first + 1;
    req[who] = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    int lat, c0, c1, n, a0, awv0, wv0, bw0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack0", {31'd0, ack[0]}, 32'd0);
    check("rst_ack1", {31'd0, ack[1]}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", {30'd0, resp}, 32'd0);
    check("rst_valids", {27'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'd0);
    arst_n = 1'b1;
    settle();

    // Write then read back through the other requester.
    access(0, 1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, lat);
    check("wr_latency_le5", {31'd0, lat <= 5}, 32'd1);
    access(1, 1'b0, 4'h4, 32'h0, 4'h0, 2'b00, lat);
    check("rd_latency_le5", {31'd0, lat <= 5}, 32'd1);
    check("wr_rd_rdata", rdata, 32'hDEADBEEF);
    check("wr_rd_resp", {30'd0, resp}, 32'd0);

    access(0, 1'b1, 4'h0, 32'h01010101, 4'hF, 2'b00, lat);
    access(1, 1'b1, 4'h8, 32'h08080808, 4'hF, 2'b00, lat);

    // Contention: last grant was requester 1, so requester 0 wins first.
    expect_access(0, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00);
    expect_access(1, 1'b0, 4'h8, 32'h0, 4'h0, 2'b00);
    expect_access(0, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00);
    expect_access(1, 1'b0, 4'h8, 32'h0, 4'h0, 2'b00);
    we[0] = 1'b0; addr[0] = 4'h0; we[1] = 1'b0; addr[1] = 4'h8;
    req[0] = 1'b1; req[1] = 1'b1;
    c0 = 0; c1 = 0; n = 0;
    while ((c0 < 2 || c1 < 2) && n < 200) begin
      @(negedge clk);
      n++;
      if (ack[0]) begin c0++; if (c0 == 2) req[0] = 1'b0; end
      if (ack[1]) begin c1++; if (c1 == 2) req[1] = 1'b0; end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    check("contention_acks0", c0, 2);
    check("contention_acks1", c1, 2);
    check("contention_rdata", rdata, 32'h08080808);

    // Partial strobe.
    access(0, 1'b1, 4'hC, 32'hAABBCCDD, 4'hF, 2'b00, lat);
    access(1, 1'b1, 4'hC, 32'h11223344, 4'h3, 2'b00, lat);
    access(0, 1'b0, 4'hC, 32'h0, 4'h0, 2'b00, lat);
    check("strobe_rdata", rdata, 32'hAABB3344);

    // Error response followed by OKAY.
    err_mode = 1'b1;
    access(0, 1'b0, 4'h8, 32'h0, 4'h0, 2'b10, lat);
    check("err_resp", {30'd0, resp}, 32'd2);
    err_mode = 1'b0;
    access(1, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, lat);
    check("err_clear_resp", {30'd0, resp}, 32'd0);
    check("err_clear_rdata", rdata, 32'h01010101);

    // Backpressure on AW and B.
    aw_hold = 3; w_hold = 1; b_delay = 2;
    settle();
    awv0 = awv_total; wv0 = wv_total; bw0 = bw_total; a0 = ack_total;
    access(1, 1'b1, 4'h0, 32'h12345678, 4'hF, 2'b00, lat);
    settle();
    check("bp_awvalid_cycles", awv_total - awv0, 3);
    check("bp_wvalid_cycles", wv_total - wv0, 1);
    check("bp_bready_wait", bw_total - bw0, 2);
    check("bp_ack_count", ack_total - a0, 1);
    check("bp_resp", {30'd0, resp}, 32'd0);
    aw_hold = 1; b_delay = 0;

    // Reset in the middle of a write.
    aw_hold = 6; w_hold = 6;
    settle();
    a0 = ack_total;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'hC; wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awvalid && n < 20);
    check("mid_awvalid_seen", {31'd0, bus.awvalid}, 32'd1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", {31'd0, bus.awvalid}, 32'd0);
    check("mid_rst_wvalid", {31'd0, bus.wvalid}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_no_ack", {31'd0, ack[0] || ack[1]}, 32'd0);
    aw_hold = 1; w_hold = 1;
    model_rdata = 32'h0;
    arst_n = 1'b1;
    settle();
    check("mid_rst_ack_total", ack_total, a0);
    access(1, 1'b0, 4'hC, 32'h0, 4'h0, 2'b00, lat);
    check("post_rst_rdata", rdata, 32'hAABB3344);
    access(0, 1'b1, 4'h4, 32'h55AA55AA, 4'hC, 2'b00, lat);
    access(0, 1'b0, 4'h4, 32'h0, 4'h0, 2'b00, lat);
    check("post_rst_strobe", rdata, 32'h55AABEEF);

    repeat (3) settle();
    check("expectations_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
